blake2_msg_feeder: RTL

Byte-stream transmitter sitting upstream of the `blake2` core. Accepts an arbitrary-length message from a host over a valid/ready byte stream and drives the core's block input. It splits the message into BB-byte blocks, zero-pads the final block, and generates block index, first/last flags and the total byte count `ll`. It also consumes the core's hash byte stream and signals completion, so one start/done transaction covers a full hash.

---
 rtl/blake2_msg_feeder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/blake2_msg_feeder.sv
// Host byte-stream to blake2 block feeder: splits, zero-pads, tracks ll and hash completion.
// Optional key block prepend enabled by defining BLAKE2_FEEDER_KEY_EN.
module blake2_msg_feeder #(
    parameter int unsigned BB    = 128,
    parameter int unsigned LL_W  = 128,
    parameter int unsigned NN_W  = 7,
    parameter int unsigned IDX_W = $clog2(BB)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start_i,
    input  logic             empty_i,
    input  logic [NN_W-1:0]  nn_i,
`ifdef BLAKE2_FEEDER_KEY_EN
    input  logic [NN_W-1:0]  kk_i,
`endif
    input  logic             s_valid_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    input  logic             core_ready_i,
    output logic             data_v_o,
    output logic [7:0]       data_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic             block_first_o,
    output logic             block_last_o,
    output logic [LL_W-1:0]  ll_o,
    input  logic             h_v_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_KEY, ST_DATA, ST_PAD, ST_WAIT_RES} state_t;

    state_t           state_q, state_d;
    logic             data_v_q, data_v_d;
    logic [7:0]       data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [LL_W-1:0]  ll_q, ll_d;
    logic [NN_W-1:0]  nn_q, nn_d;
    logic [NN_W-1:0]  hcnt_q, hcnt_d;
    logic             empty_q, empty_d;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic             first_blk_q, first_blk_d;
    logic             last_blk_q, last_blk_d;
    logic             key_blk_q, key_blk_d;
    logic             done_q, done_d;
`ifdef BLAKE2_FEEDER_KEY_EN
    logic [NN_W-1:0]  key_rem_q, key_rem_d;
`endif

    logic             slot_free, accept, last_pos;
    logic             load, load_last, load_first;
    logic [7:0]       load_data;
    logic [IDX_W-1:0] load_idx, pos_inc;

    assign slot_free = ~data_v_q | core_ready_i;
    assign s_ready_o = ((state_q == ST_KEY) || (state_q == ST_DATA)) && slot_free;
    assign accept    = s_valid_i & s_ready_o;
    assign last_pos  = (pos_q == IDX_W'(BB - 1));
    assign pos_inc   = last_pos ? '0 : pos_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        data_v_d    = data_v_q;
        data_d      = data_q;
        idx_d       = idx_q;
        first_d     = first_q;
        last_d      = last_q;
        ll_d        = ll_q;
        nn_d        = nn_q;
        hcnt_d      = hcnt_q;
        empty_d     = empty_q;
        pos_d       = pos_q;
        first_blk_d = first_blk_q;
        last_blk_d  = last_blk_q;
        key_blk_d   = key_blk_q;
        done_d      = 1'b0;
`ifdef BLAKE2_FEEDER_KEY_EN
        key_rem_d   = key_rem_q;
`endif
        load        = 1'b0;
        load_data   = 8'h00;
        load_idx    = pos_q;
        load_first  = first_blk_q;
        load_last   = last_blk_q;

        if (data_v_q && core_ready_i)
            data_v_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nn_d        = nn_i;
                    empty_d     = empty_i;
                    hcnt_d      = '0;
                    ll_d        = '0;
                    pos_d       = '0;
                    first_blk_d = 1'b1;
                    last_blk_d  = empty_i;
                    key_blk_d   = 1'b0;
`ifdef BLAKE2_FEEDER_KEY_EN
                    key_rem_d   = kk_i;
                    if (kk_i != '0) begin
                        state_d   = ST_KEY;
                        ll_d      = LL_W'(BB);
                        key_blk_d = 1'b1;
                    end else
`endif
                    if (empty_i) begin
                        state_d = ST_PAD;
                        // First pad byte goes out on the start edge when the slot allows.
                        if (slot_free) begin
                            load       = 1'b1;
                            load_idx   = '0;
                            load_first = 1'b1;
                            load_last  = 1'b1;
                            pos_d      = IDX_W'(1);
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
`ifdef BLAKE2_FEEDER_KEY_EN
            ST_KEY: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = s_data_i;
                    pos_d     = pos_inc;
                    key_rem_d = key_rem_q - NN_W'(1);
                    if (key_rem_q == NN_W'(1)) begin
                        if (!last_pos) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d     = empty_q ? ST_WAIT_RES : ST_DATA;
                            first_blk_d = 1'b0;
                            last_blk_d  = empty_q;
                            key_blk_d   = 1'b0;
                        end
                    end
                end
            end
`endif
            ST_DATA: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = s_data_i;
                    load_last = s_last_i | last_blk_q;
                    ll_d      = ll_q + LL_W'(1);
                    pos_d     = pos_inc;
                    if (s_last_i) begin
                        last_blk_d = 1'b1;
                        state_d    = last_pos ? ST_WAIT_RES : ST_PAD;
                    end else if (last_pos) begin
                        first_blk_d = 1'b0;
                    end
                end
            end
            ST_PAD: begin
                if (slot_free) begin
                    load  = 1'b1;
                    pos_d = pos_inc;
                    if (last_pos) begin
                        if (key_blk_q && !empty_q) begin
                            state_d     = ST_DATA;
                            first_blk_d = 1'b0;
                            last_blk_d  = 1'b0;
                            key_blk_d   = 1'b0;
                        end else begin
                            state_d = ST_WAIT_RES;
                        end
                    end
                end
            end
            ST_WAIT_RES: begin
                if (h_v_i) begin
                    hcnt_d = hcnt_q + NN_W'(1);
                    if (hcnt_d == nn_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            data_v_d = 1'b1;
            data_d   = load_data;
            idx_d    = load_idx;
            first_d  = load_first;
            last_d   = load_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            data_v_q    <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            ll_q        <= '0;
            nn_q        <= '0;
            hcnt_q      <= '0;
            empty_q     <= 1'b0;
            pos_q       <= '0;
            first_blk_q <= 1'b0;
            last_blk_q  <= 1'b0;
            key_blk_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef BLAKE2_FEEDER_KEY_EN
            key_rem_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_v_q    <= data_v_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            last_q      <= last_d;
            ll_q        <= ll_d;
            nn_q        <= nn_d;
            hcnt_q      <= hcnt_d;
            empty_q     <= empty_d;
            pos_q       <= pos_d;
            first_blk_q <= first_blk_d;
            last_blk_q  <= last_blk_d;
            key_blk_q   <= key_blk_d;
            done_q      <= done_d;
`ifdef BLAKE2_FEEDER_KEY_EN
            key_rem_q   <= key_rem_d;
`endif
        end
    end

    assign data_v_o      = data_v_q;
    assign data_o        = data_q;
    assign data_idx_o    = idx_q;
    assign block_first_o = first_q;
    assign block_last_o  = last_q;
    assign ll_o          = ll_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;

endmodule
